// File: rtl/wb_sched_pkg.sv
// Shared definitions for the writeback scheduler: unit tags, source indices
// and the register-file word/address/tag types.
package wb_sched_pkg;

  localparam int TAG_W     = 3;
  localparam int WORD_W    = 32;
  localparam int REGADDR_W = 5;
  localparam int NSRC      = 4;
  localparam int SRC_W     = 2;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REGADDR_W-1:0] regaddr_t;
  typedef logic [TAG_W-1:0]     regtag_t;
  typedef logic [SRC_W-1:0]     src_idx_t;

  // Tag values stored in the register status file
  localparam regtag_t UNLOCKED   = 3'd0;
  localparam regtag_t ALU_MASTER = 3'd1;
  localparam regtag_t ALU_SALVER = 3'd2;
  localparam regtag_t LOAD_STORE = 3'd3;
  localparam regtag_t BRANCH     = 3'd4;

  localparam src_idx_t SRC_ALU_MASTER = 2'd0;
  localparam src_idx_t SRC_ALU_SLAVE  = 2'd1;
  localparam src_idx_t SRC_LOAD_STORE = 2'd2;
  localparam src_idx_t SRC_BRANCH     = 2'd3;

  function automatic src_idx_t rr_next(input src_idx_t last);
    return last + 2'd1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-source result FIFO; pointers wrap freely, count is one bit wider
// so full and empty are distinguishable. Flush clears occupancy only.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even if its head leaves on the same edge
  assign do_push = en && !flush && push && !full;
  assign do_pop  = en && !flush && pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_sched.sv
// Writeback scheduler: four per-source FIFOs, round-robin dual-port grant onto
// the register-file write ports, registered write strobes/address/data/tag.
//
// Handshake: a result on source i is taken at a clock edge exactly when
// src_valid[i] && src_ready[i] && rdy && !flush; src_ready[i] depends only on
// FIFO occupancy, never on src_valid. Write ports carry no back-pressure.
module wb_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 3,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic [3:0]          src_valid,
  output logic [3:0]          src_ready,
  input  logic [4*ADDR_W-1:0] src_addr,
  input  logic [4*DATA_W-1:0] src_data,
  input  logic [4*TAG_W-1:0]  src_tag,
  output logic                en_w0,
  output logic                en_w1,
  output logic [ADDR_W-1:0]   reg_write_addr0,
  output logic [ADDR_W-1:0]   reg_write_addr1,
  output logic [DATA_W-1:0]   write_data0,
  output logic [DATA_W-1:0]   write_data1,
  output logic [TAG_W-1:0]    write_tag0,
  output logic [TAG_W-1:0]    write_tag1
);

  import wb_sched_pkg::*;

  localparam int ENT_W = ADDR_W + DATA_W + TAG_W;

  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic [NSRC-1:0]   full;
  logic [NSRC-1:0]   empty;
  logic [ENT_W-1:0]  head      [NSRC];
  logic [ADDR_W-1:0] head_addr [NSRC];
  logic [DATA_W-1:0] head_data [NSRC];
  logic [TAG_W-1:0]  head_tag  [NSRC];

  src_idx_t rr;
  logic     g0;
  logic     g1;
  src_idx_t s0;
  src_idx_t s1;
  logic     advance;

  assign advance = rdy && !flush;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    wb_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .en    (rdy),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   ({src_addr[i*ADDR_W +: ADDR_W],
               src_data[i*DATA_W +: DATA_W],
               src_tag[i*TAG_W +: TAG_W]}),
      .head  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    assign {head_addr[i], head_data[i], head_tag[i]} = head[i];
    assign src_ready[i] = !full[i];
    assign push[i]      = src_valid[i] && !full[i] && advance;
    assign pop[i]       = advance && ((g0 && (s0 == SRC_W'(i))) ||
                                      (g1 && (s1 == SRC_W'(i))));
  end

  // Scan heads from rr; port 1 skips a head that would write port 0's
  // nonzero register in the same cycle, leaving it queued.
  always_comb begin
    src_idx_t idx;
    g0  = 1'b0;
    g1  = 1'b0;
    s0  = '0;
    s1  = '0;
    idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = rr + SRC_W'(k);
      if (!empty[idx]) begin
        if (!g0) begin
          g0 = 1'b1;
          s0 = idx;
        end else if (!g1 && ((head_addr[idx] != head_addr[s0]) ||
                             (head_addr[idx] == '0))) begin
          g1 = 1'b1;
          s1 = idx;
        end
      end
    end
  end

  // Address-0 grants still consume a slot but never strobe the write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr              <= '0;
      en_w0           <= 1'b0;
      en_w1           <= 1'b0;
      reg_write_addr0 <= '0;
      reg_write_addr1 <= '0;
      write_data0     <= '0;
      write_data1     <= '0;
      write_tag0      <= '0;
      write_tag1      <= '0;
    end else if (rdy) begin
      if (flush) begin
        rr    <= '0;
        en_w0 <= 1'b0;
        en_w1 <= 1'b0;
      end else begin
        en_w0 <= g0 && (head_addr[s0] != '0);
        en_w1 <= g1 && (head_addr[s1] != '0);
        if (g0) begin
          reg_write_addr0 <= head_addr[s0];
          write_data0     <= head_data[s0];
          write_tag0      <= head_tag[s0];
        end
        if (g1) begin
          reg_write_addr1 <= head_addr[s1];
          write_data1     <= head_data[s1];
          write_tag1      <= head_tag[s1];
        end
        if (g1)      rr <= rr_next(s1);
        else if (g0) rr <= rr_next(s0);
      end
    end
  end

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: per-cycle checks plus a write-port scoreboard
// that expects each queued result to be written exactly once, in order.
module tb_wb_sched;
  import wb_sched_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              flush;
  logic [3:0]        src_valid;
  logic [3:0]        src_ready;
  logic [4*AW-1:0]   src_addr;
  logic [4*DW-1:0]   src_data;
  logic [4*TW-1:0]   src_tag;
  logic              en_w0;
  logic              en_w1;
  logic [AW-1:0]     reg_write_addr0;
  logic [AW-1:0]     reg_write_addr1;
  logic [DW-1:0]     write_data0;
  logic [DW-1:0]     write_data1;
  logic [TW-1:0]     write_tag0;
  logic [TW-1:0]     write_tag1;

  int                tests_run    = 0;
  int                tests_failed = 0;
  logic [AW+DW-1:0]  exp_q[$];
  logic              rdy_q;

  logic              t4_rdy  [8];
  logic [3:0]        t4_v    [8];
  logic [DW-1:0]     t4_d0   [8];
  logic [DW-1:0]     t4_d3   [8];
  logic              t4_en0  [8];
  logic [DW-1:0]     t4_wd0  [8];
  logic              t4_rdy3 [8];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1);
  end

  wb_sched #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .TAG_W  (TW),
    .DEPTH  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .flush           (flush),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .src_addr        (src_addr),
    .src_data        (src_data),
    .src_tag         (src_tag),
    .en_w0           (en_w0),
    .en_w1           (en_w1),
    .reg_write_addr0 (reg_write_addr0),
    .reg_write_addr1 (reg_write_addr1),
    .write_data0     (write_data0),
    .write_data1     (write_data1),
    .write_tag0      (write_tag0),
    .write_tag1      (write_tag1)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [AW+DW-1:0] got);
    if (exp_q.size() == 0) check({tag, "_extra"}, 64'(got), 64'(0));
    else                   check(tag, 64'(got), 64'(exp_q.pop_front()));
  endtask

  // Writes count only after edges where rdy was high (held outputs are not new)
  always @(posedge clk) rdy_q <= rdy;

  always @(negedge clk) begin
    if (rst === 1'b1 && rdy_q === 1'b1) begin
      if (en_w0 === 1'b1) sb_pop("sb_port0", {reg_write_addr0, write_data0});
      if (en_w1 === 1'b1) sb_pop("sb_port1", {reg_write_addr1, write_data1});
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [TW-1:0] t);
    src_addr[i*AW +: AW] = a;
    src_data[i*DW +: DW] = d;
    src_tag[i*TW +: TW]  = t;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst       = 1'b0;
    rdy       = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    src_tag   = '0;
    t4_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    t4_v    = '{4'h9, 4'h9, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
    t4_d0   = '{32'hA0, 32'hA1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    t4_d3   = '{32'h30, 32'h31, 32'h32, 32'h32, 32'h33, 32'h33, 32'h33, 32'h33};
    t4_en0  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t4_wd0  = '{32'h0, 32'hA0, 32'h30, 32'hA1, 32'hA1, 32'h31, 32'h32, 32'h0};
    t4_rdy3 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_ready", 64'(src_ready), 64'(4'hf));
    check("rst_en_w0", 64'(en_w0), 64'(0));
    check("rst_en_w1", 64'(en_w1), 64'(0));
    check("rst_addr0", 64'(reg_write_addr0), 64'(0));
    check("rst_data0", 64'(write_data0), 64'(0));
    check("rst_tag0", 64'(write_tag0), 64'(0));
    check("rst_rr", 64'(dut.rr), 64'(0));

    // single push on load/store source
    set_src(2, 5'd5, 32'hDEADBEEF, LOAD_STORE);
    src_valid = 4'b0100;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick();
    src_valid = '0;
    check("t1_no_bypass", 64'(en_w0), 64'(0));
    tick();
    check("t1_en_w0", 64'(en_w0), 64'(1));
    check("t1_addr0", 64'(reg_write_addr0), 64'(5));
    check("t1_data0", 64'(write_data0), 64'(32'hDEADBEEF));
    check("t1_tag0", 64'(write_tag0), 64'(LOAD_STORE));
    check("t1_en_w1", 64'(en_w1), 64'(0));
    check("t1_rr", 64'(dut.rr), 64'(3));
    tick();
    check("t1_strobe_once", 64'(en_w0), 64'(0));

    // two entries queued, then flushed before they can be written
    set_src(1, 5'd3, 32'h11, ALU_SALVER);
    set_src(2, 5'd4, 32'h22, LOAD_STORE);
    src_valid = 4'b0110;
    tick();
    src_valid = '0;
    do_flush();
    check("fl_en_w0", 64'(en_w0), 64'(0));
    check("fl_en_w1", 64'(en_w1), 64'(0));
    check("fl_ready", 64'(src_ready), 64'(4'hf));
    check("fl_rr", 64'(dut.rr), 64'(0));
    tick();
    check("fl_dropped_w0", 64'(en_w0), 64'(0));
    check("fl_dropped_w1", 64'(en_w1), 64'(0));

    // all four sources, rr = 0
    for (int i = 0; i < 4; i++) begin
      set_src(i, AW'(i + 1), 32'h100 + 32'(i), TW'(i + 1));
      exp_q.push_back({AW'(i + 1), 32'h100 + 32'(i)});
    end
    src_valid = 4'hf;
    tick();
    src_valid = '0;
    tick();
    check("t2_c1_en0", 64'(en_w0), 64'(1));
    check("t2_c1_addr0", 64'(reg_write_addr0), 64'(1));
    check("t2_c1_en1", 64'(en_w1), 64'(1));
    check("t2_c1_addr1", 64'(reg_write_addr1), 64'(2));
    check("t2_c1_data1", 64'(write_data1), 64'(32'h101));
    tick();
    check("t2_c2_addr0", 64'(reg_write_addr0), 64'(3));
    check("t2_c2_addr1", 64'(reg_write_addr1), 64'(4));
    check("t2_c2_both", 64'({en_w0, en_w1}), 64'(2'b11));
    check("t2_c2_tag1", 64'(write_tag1), 64'(4));
    check("t2_rr", 64'(dut.rr), 64'(0));
    tick();
    check("t2_idle", 64'({en_w0, en_w1}), 64'(2'b00));

    // same destination on sources 0 and 1
    set_src(0, 5'd7, 32'hAAAA0000, ALU_MASTER);
    set_src(1, 5'd7, 32'hBBBB0000, ALU_SALVER);
    exp_q.push_back({5'd7, 32'hAAAA0000});
    exp_q.push_back({5'd7, 32'hBBBB0000});
    src_valid = 4'b0011;
    tick();
    src_valid = '0;
    tick();
    check("t3_c1_en0", 64'(en_w0), 64'(1));
    check("t3_c1_data0", 64'(write_data0), 64'(32'hAAAA0000));
    check("t3_c1_en1", 64'(en_w1), 64'(0));
    tick();
    check("t3_c2_en0", 64'(en_w0), 64'(1));
    check("t3_c2_data0", 64'(write_data0), 64'(32'hBBBB0000));
    check("t3_c2_tag0", 64'(write_tag0), 64'(ALU_SALVER));
    check("t3_c2_en1", 64'(en_w1), 64'(0));
    check("t3_rr", 64'(dut.rr), 64'(2));
    tick();
    do_flush();

    // addr-0 entry takes port 0 without a strobe
    set_src(0, 5'd0, 32'h0C0C, ALU_MASTER);
    set_src(1, 5'd9, 32'h9999, ALU_SALVER);
    exp_q.push_back({5'd9, 32'h9999});
    src_valid = 4'b0011;
    tick();
    src_valid = '0;
    tick();
    check("t6_en0", 64'(en_w0), 64'(0));
    check("t6_en1", 64'(en_w1), 64'(1));
    check("t6_addr1", 64'(reg_write_addr1), 64'(9));
    check("t6_data1", 64'(write_data1), 64'(32'h9999));
    check("t6_addr0", 64'(reg_write_addr0), 64'(0));
    tick();
    do_flush();

    // source 3 held valid; fills behind an addr conflict with source 0, rdy stall
    for (int k = 0; k < 8; k++) begin
      if (t4_en0[k] && k > 0 && t4_wd0[k] != t4_wd0[k-1] && t4_rdy[k])
        exp_q.push_back({5'd12, t4_wd0[k]});
    end
    for (int k = 0; k < 8; k++) begin
      set_src(0, 5'd12, t4_d0[k], ALU_MASTER);
      set_src(3, 5'd12, t4_d3[k], BRANCH);
      rdy       = t4_rdy[k];
      src_valid = t4_v[k];
      tick();
      check($sformatf("t4_e%0d_en0", k + 1), 64'(en_w0), 64'(t4_en0[k]));
      if (t4_en0[k]) check($sformatf("t4_e%0d_data0", k + 1), 64'(write_data0), 64'(t4_wd0[k]));
      check($sformatf("t4_e%0d_en1", k + 1), 64'(en_w1), 64'(0));
      check($sformatf("t4_e%0d_ready3", k + 1), 64'(src_ready[3]), 64'(t4_rdy3[k]));
    end
    rdy       = 1'b1;
    src_valid = '0;

    // reset in the middle of operation discards the queued entry
    set_src(0, 5'd3, 32'h5555, ALU_MASTER);
    src_valid = 4'b0001;
    tick();
    src_valid = '0;
    rst = 1'b0;
    #1;
    check("mr_en0", 64'(en_w0), 64'(0));
    check("mr_ready", 64'(src_ready), 64'(4'hf));
    tick();
    rst = 1'b1;
    tick();
    check("mr_discard", 64'(en_w0), 64'(0));
    tick();
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
